spi_flash_arbiter: RTL

Shares one spi_flash_reader between N_REQ requesters, for example vgen frame fetch plus a palette or config loader. It arbitrates whole transactions (addr/len/go) round-robin and launches the granted one on the reader. It steers the reader's byte stream back to the owning requester and signals transaction completion. It sits between the requesters and spi_flash_reader, and all logic is in the clk domain.

---
 rtl/spi_flash_arbiter_pkg.sv | 14 +
 rtl/spi_arb_rr_pick.sv | 49 ++++
 rtl/spi_flash_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/spi_flash_arbiter_pkg.sv
// rtl/spi_flash_arbiter_pkg.sv - shared state encoding and default widths for the flash arbiter
package spi_flash_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   localparam int ADDR_W_DEF = 24;
   localparam int LEN_W_DEF  = 16;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// rtl/spi_arb_rr_pick.sv - combinational winner pick; SPI_ARB_FIXED_PRIO_EN selects lowest-index priority
module spi_arb_rr_pick #(
   parameter int N_REQ = 2,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_last,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);

`ifdef SPI_ARB_FIXED_PRIO_EN
   // the round-robin pointer has no say in fixed-priority mode
   logic rr_last_unused;
   assign rr_last_unused = ^rr_last;

   // lowest set index wins; scanning downward leaves the smallest one in grant_idx
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) grant_idx = IDX_W'(i);
      end
      if (any_req) grant[grant_idx] = 1'b1;
   end
`else
   // first set request after rr_last, wrapping, so the previous owner goes last
   always_comb begin
      logic found;
      int   idx;
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(rr_last) + k) % N_REQ;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(idx);
         end
      end
      if (any_req) grant[grant_idx] = 1'b1;
   end
`endif

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - whole-transaction arbiter sharing one spi_flash_reader; SPI_ARB_FIXED_PRIO_EN = fixed priority
module spi_flash_arbiter
   import spi_flash_arbiter_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*LEN_W-1:0]  req_len,
   input  logic [N_REQ-1:0]        req_go,
   output logic [N_REQ-1:0]        req_ack,
   output logic [N_REQ-1:0]        req_done,
   output logic [7:0]              req_data,
   output logic [N_REQ-1:0]        req_valid,
   output logic [ADDR_W-1:0]       sr_addr,
   output logic [LEN_W-1:0]        sr_len,
   output logic                    sr_go,
   input  logic                    sr_rdy,
   input  logic [7:0]              sr_data,
   input  logic                    sr_valid
);

   localparam int IDX_W = $clog2(N_REQ);

   arb_state_t        state;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  rr_last;
   logic              busy_seen;
   logic [N_REQ-1:0]  grant;
   logic [IDX_W-1:0]  grant_idx;
   logic              any_req;
   logic [N_REQ-1:0]  owner_onehot;
   logic [ADDR_W-1:0] sel_addr;
   logic [LEN_W-1:0]  sel_len;

   spi_arb_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req       (req_go),
      .rr_last   (rr_last),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign owner_onehot = N_REQ'(1) << owner;

   // the ack must coincide with the reader accepting, so it follows sr_rdy directly
   assign req_ack = (state == ST_ISSUE && sr_rdy) ? owner_onehot : '0;

   // one-hot mux of the winning requester's address and length
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
            sel_len  = sel_len  | req_len[i*LEN_W +: LEN_W];
         end
      end
   end

   // transaction FSM: grant in IDLE, hold sr_go until accepted, wait for reader busy->idle, pulse done
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner     <= '0;
         rr_last   <= IDX_W'(N_REQ - 1);
         busy_seen <= 1'b0;
         sr_go     <= 1'b0;
         sr_addr   <= '0;
         sr_len    <= '0;
         req_done  <= '0;
      end else begin
         req_done <= '0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner   <= grant_idx;
                  sr_addr <= sel_addr;
                  sr_len  <= sel_len;
                  sr_go   <= 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sr_rdy) begin
                  sr_go     <= 1'b0;
                  busy_seen <= 1'b0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!sr_rdy) busy_seen <= 1'b1;
               if (busy_seen && sr_rdy) begin
                  req_done <= owner_onehot;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               rr_last <= owner;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // byte path: one register stage, steered to the owner only while its transfer is live
   always_ff @(posedge clk) begin
      if (rst) begin
         req_data  <= '0;
         req_valid <= '0;
      end else begin
         if (sr_valid) req_data <= sr_data;
         req_valid <= (sr_valid && (state == ST_WAIT || state == ST_DONE)) ? owner_onehot : '0;
      end
   end

endmodule
